// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_unit
// Description : Pipeline hazard controller for a 5-stage RV32 core. Produces
//               the E-stage forwarding selects, the load-use stall, the
//               branch/jump flushes, and a pipeline freeze while a multi-cycle
//               execute op (mul/div) is busy. A watchdog releases the freeze
//               after MC_TIMEOUT busy cycles (0 disables the watchdog).
//               Optional macro HAZARD_PERF_CNT_EN adds the stall-cycle and
//               flush-event performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_unit #(
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [4:0]       rs1_d_i,
    input  logic [4:0]       rs2_d_i,
    input  logic [4:0]       rs1_e_i,
    input  logic [4:0]       rs2_e_i,
    input  logic [4:0]       rd_e_i,
    input  logic [4:0]       rd_m_i,
    input  logic [4:0]       rd_w_i,
    input  logic             reg_write_m_i,
    input  logic             reg_write_w_i,
    input  logic [1:0]       result_src_e_i,
    input  logic             pc_src_e_i,
    input  logic             mc_start_e_i,
    input  logic             mc_done_i,
    output logic [1:0]       forward_a_e_o,
    output logic [1:0]       forward_b_e_o,
    output logic             stall_f_o,
    output logic             stall_d_o,
    output logic             stall_e_o,
    output logic             flush_d_o,
    output logic             flush_e_o,
    output logic             flush_m_o,
    output logic             mc_timeout_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic [CNT_W-1:0] flush_events_o
`endif
);

    // Busy counter must be able to hold MC_TIMEOUT itself.
    localparam int CNT_BITS = (MC_TIMEOUT < 2) ? 1 : $clog2(MC_TIMEOUT + 1);
    localparam bit WDOG_EN  = (MC_TIMEOUT != 0);
    localparam logic [CNT_BITS-1:0] TIMEOUT_VAL = CNT_BITS'(MC_TIMEOUT);
    localparam logic [CNT_BITS-1:0] CNT_ONE     = CNT_BITS'(1);

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_MC_BUSY = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;

    logic       lw_stall;
    logic [1:0] fwd_a, fwd_b;
    logic       stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mc_timeout;

    // M-stage ALU result wins over W-stage result; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        logic [1:0] sel;
        sel = 2'b00;
        if (reg_write_m_i && (rd_m_i != 5'd0) && (rd_m_i == rs)) begin
            sel = 2'b10;
        end else if (reg_write_w_i && (rd_w_i != 5'd0) && (rd_w_i == rs)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    // Operand forwarding selects and the load-use hazard detect.
    always_comb begin
        fwd_a    = fwd_sel(rs1_e_i);
        fwd_b    = fwd_sel(rs2_e_i);
        lw_stall = (result_src_e_i == 2'b01) && (rd_e_i != 5'd0) &&
                   ((rd_e_i == rs1_d_i) || (rd_e_i == rs2_d_i));
    end

    // Next-state logic and the stall/flush controls for each state.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stall_f    = 1'b0;
        stall_d    = 1'b0;
        stall_e    = 1'b0;
        flush_d    = 1'b0;
        flush_e    = 1'b0;
        flush_m    = 1'b0;
        mc_timeout = 1'b0;
        case (state_q)
            ST_RUN: begin
                // A multi-cycle op in E overrides any load-use or branch view
                // of the same instruction.
                if (mc_start_e_i) begin
                    if (!mc_done_i) begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        stall_e = 1'b1;
                        flush_m = 1'b1;
                        state_d = ST_MC_BUSY;
                        cnt_d   = CNT_ONE;
                    end
                end else begin
                    stall_f = lw_stall;
                    stall_d = lw_stall;
                    flush_d = pc_src_e_i;
                    flush_e = lw_stall | pc_src_e_i;
                end
            end
            ST_MC_BUSY: begin
                cnt_d = cnt_q + CNT_ONE;
                if (mc_done_i) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else if (WDOG_EN && (cnt_q == TIMEOUT_VAL)) begin
                    mc_timeout = 1'b1;
                    state_d    = ST_RUN;
                    cnt_d      = '0;
                end else begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    stall_e = 1'b1;
                    flush_m = 1'b1;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are held quiet while reset is asserted.
    always_comb begin
        forward_a_e_o = rst_n_i ? fwd_a      : 2'b00;
        forward_b_e_o = rst_n_i ? fwd_b      : 2'b00;
        stall_f_o     = rst_n_i & stall_f;
        stall_d_o     = rst_n_i & stall_d;
        stall_e_o     = rst_n_i & stall_e;
        flush_d_o     = rst_n_i & flush_d;
        flush_e_o     = rst_n_i & flush_e;
        flush_m_o     = rst_n_i & flush_m;
        mc_timeout_o  = rst_n_i & mc_timeout;
    end

    // FSM state and busy-cycle counter registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_events_q, flush_events_d;

    // Free-running wrap-around event counters.
    always_comb begin
        stall_cycles_d = stall_cycles_q + {{(CNT_W-1){1'b0}}, stall_f_o};
        flush_events_d = flush_events_q + {{(CNT_W-1){1'b0}}, (flush_d_o | flush_e_o)};
    end

    // Performance counter registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    assign stall_cycles_o = stall_cycles_q;
    assign flush_events_o = flush_events_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_unit
// Description : Self-checking bench for hazard_unit. Stimulus pushes the
//               expected per-cycle response into a queue; a monitor pops and
//               compares on the falling edge. Directed scenarios followed by
//               randomized traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_unit;

    localparam int TO    = 8;
    localparam int CNT_W = 32;

    logic       clk_i = 1'b0;
    logic       rst_n_i = 1'b0;
    logic [4:0] rs1_d_i = '0, rs2_d_i = '0, rs1_e_i = '0, rs2_e_i = '0;
    logic [4:0] rd_e_i = '0, rd_m_i = '0, rd_w_i = '0;
    logic       reg_write_m_i = 1'b0, reg_write_w_i = 1'b0;
    logic [1:0] result_src_e_i = '0;
    logic       pc_src_e_i = 1'b0, mc_start_e_i = 1'b0, mc_done_i = 1'b0;
    logic [1:0] forward_a_e_o, forward_b_e_o;
    logic       stall_f_o, stall_d_o, stall_e_o, flush_d_o, flush_e_o, flush_m_o, mc_timeout_o;
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles_o, flush_events_o;
`endif

    hazard_unit #(.MC_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .rs1_d_i        (rs1_d_i),
        .rs2_d_i        (rs2_d_i),
        .rs1_e_i        (rs1_e_i),
        .rs2_e_i        (rs2_e_i),
        .rd_e_i         (rd_e_i),
        .rd_m_i         (rd_m_i),
        .rd_w_i         (rd_w_i),
        .reg_write_m_i  (reg_write_m_i),
        .reg_write_w_i  (reg_write_w_i),
        .result_src_e_i (result_src_e_i),
        .pc_src_e_i     (pc_src_e_i),
        .mc_start_e_i   (mc_start_e_i),
        .mc_done_i      (mc_done_i),
        .forward_a_e_o  (forward_a_e_o),
        .forward_b_e_o  (forward_b_e_o),
        .stall_f_o      (stall_f_o),
        .stall_d_o      (stall_d_o),
        .stall_e_o      (stall_e_o),
        .flush_d_o      (flush_d_o),
        .flush_e_o      (flush_e_o),
        .flush_m_o      (flush_m_o),
        .mc_timeout_o   (mc_timeout_o)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cycles_o (stall_cycles_o),
        .flush_events_o (flush_events_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic       rst_n;
        logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
        logic       rwm, rww;
        logic [1:0] rsrc;
        logic       pc, mcs, mcd;
    } stim_t;

    typedef struct packed {
        logic [1:0] fa, fb;
        logic       sf, sd, se, fd, fe, fm, to;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;

    // Behavioural model: is an op in flight, and how many cycles has it frozen the pipe.
    bit          m_busy = 0;
    int          m_frozen = 0;
    logic [31:0] m_stalls = 0, m_flushes = 0;   // totals including the current cycle
    logic [31:0] m_stalls_reg = 0, m_flushes_reg = 0;  // totals visible in the counters

    function automatic logic [1:0] model_fwd(input stim_t s, input logic [4:0] rs);
        if (s.rwm && s.rd_m == rs && s.rd_m != 0) return 2'b10;
        if (s.rww && s.rd_w == rs && s.rd_w != 0) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model(input stim_t s, output exp_t e);
        bit lw, freeze;
        e = '0;
        m_stalls_reg  = m_stalls;
        m_flushes_reg = m_flushes;
        if (!s.rst_n) begin
            m_busy = 0; m_frozen = 0; m_stalls = 0; m_flushes = 0;
            m_stalls_reg = 0; m_flushes_reg = 0;
            return;
        end
        e.fa = model_fwd(s, s.rs1_e);
        e.fb = model_fwd(s, s.rs2_e);
        freeze = 0;
        if (m_busy) begin
            if (s.mcd) m_busy = 0;
            else if (TO != 0 && m_frozen == TO) begin e.to = 1; m_busy = 0; end
            else freeze = 1;
        end else if (s.mcs) begin
            if (!s.mcd) begin freeze = 1; m_busy = 1; m_frozen = 0; end
        end else begin
            lw = (s.rsrc == 2'b01) && s.rd_e != 0 && (s.rd_e == s.rs1_d || s.rd_e == s.rs2_d);
            e.sf = lw; e.sd = lw; e.fd = s.pc; e.fe = lw | s.pc;
        end
        if (freeze) begin
            e.sf = 1; e.sd = 1; e.se = 1; e.fm = 1; m_frozen++;
        end
        m_stalls  = m_stalls + 32'(e.sf);
        m_flushes = m_flushes + 32'(e.fd | e.fe);
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        s.rst_n = 1'b1;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        rst_n_i = s.rst_n;
        rs1_d_i = s.rs1_d; rs2_d_i = s.rs2_d; rs1_e_i = s.rs1_e; rs2_e_i = s.rs2_e;
        rd_e_i = s.rd_e; rd_m_i = s.rd_m; rd_w_i = s.rd_w;
        reg_write_m_i = s.rwm; reg_write_w_i = s.rww;
        result_src_e_i = s.rsrc; pc_src_e_i = s.pc;
        mc_start_e_i = s.mcs; mc_done_i = s.mcd;
    endtask

    // One clock cycle of stimulus: drive away from the edge, queue the expectation.
    task automatic step(input stim_t s);
        exp_t e;
        @(posedge clk_i);
        #1;
        apply(s);
        model(s, e);
        q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every cycle the DUT presents its combinational response.
    always @(negedge clk_i) begin
        exp_t e, a;
        if (q.size() > 0) begin
            e = q.pop_front();
            a = {forward_a_e_o, forward_b_e_o, stall_f_o, stall_d_o, stall_e_o,
                 flush_d_o, flush_e_o, flush_m_o, mc_timeout_o};
            n_checks++;
            if (a !== e) begin
                n_errors++;
                $display("FAIL cycle%0d outputs {fa,fb,sf,sd,se,fd,fe,fm,to}: actual=%b required=%b",
                         cyc, a, e);
            end
            cyc++;
        end
    end

    initial begin
        stim_t s;
        exp_t  dummy;
        // Reset while low: everything quiet, even with colliding inputs.
        s = idle(); s.rst_n = 0; s.rwm = 1; s.rd_m = 5; s.rs1_e = 5; s.pc = 1;
        step(s); step(s);
        s = idle(); step(s);

        // Forwarding priority and x0 handling.
        s = idle(); s.rwm = 1; s.rww = 1; s.rd_m = 5; s.rd_w = 5; s.rs1_e = 5; step(s);
        s.rd_m = 0; step(s);
        s.rs1_e = 0; step(s);
        s = idle(); s.rww = 1; s.rd_w = 7; s.rs2_e = 7; step(s);

        // Load-use: one stall cycle, then the bubble clears it.
        s = idle(); s.rsrc = 2'b01; s.rd_e = 3; s.rs2_d = 3; step(s);
        s = idle(); step(s);
        // Branch taken.
        s = idle(); s.pc = 1; step(s);
        s = idle(); step(s);
        // Five-cycle multi-cycle op.
        s = idle(); s.mcs = 1;
        repeat (5) step(s);
        s.mcd = 1; step(s);
        s = idle(); step(s);
`ifdef HAZARD_PERF_CNT_EN
        check("perf_stall_cycles", stall_cycles_o, 32'd6);
        check("perf_flush_events", flush_events_o, 32'd2);
`endif
        // Single-cycle completion: no stall at all.
        s = idle(); s.mcs = 1; s.mcd = 1; step(s);
        s = idle(); step(s);
        // Watchdog: done never arrives.
        s = idle(); s.mcs = 1;
        repeat (TO + 1) step(s);
        s = idle(); step(s);
        s = idle(); s.pc = 1; step(s);

        // Asynchronous reset in busy cycle 3.
        s = idle(); s.mcs = 1;
        repeat (3) step(s);
        s.rst_n = 0; step(s);
        #1;
        check("rst_mid_op_stall_f", 32'(stall_f_o), 32'd0);
        check("rst_mid_op_stall_e", 32'(stall_e_o), 32'd0);
        check("rst_mid_op_flush_m", 32'(flush_m_o), 32'd0);
        s = idle(); s.rst_n = 0; step(s);
        s = idle(); step(s);
        s = idle(); s.rsrc = 2'b01; s.rd_e = 9; s.rs1_d = 9; step(s);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            int k;
            s = idle();
            s.rs1_d = 5'($urandom_range(0, 7)); s.rs2_d = 5'($urandom_range(0, 7));
            s.rs1_e = 5'($urandom_range(0, 7)); s.rs2_e = 5'($urandom_range(0, 7));
            s.rd_e  = 5'($urandom_range(0, 7)); s.rd_m  = 5'($urandom_range(0, 7));
            s.rd_w  = 5'($urandom_range(0, 7));
            s.rwm = 1'($urandom_range(0, 1)); s.rww = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 199) == 0) s.rst_n = 0;
            if (m_busy) begin
                s.mcs  = 1;
                s.mcd  = ($urandom_range(0, 5) == 0);
                s.pc   = 1'($urandom_range(0, 1));
                s.rsrc = 2'($urandom_range(0, 3));
            end else begin
                k = $urandom_range(0, 5);
                case (k)
                    3: s.rsrc = 2'b01;
                    4: s.pc = 1;
                    5: begin
                        s.mcs  = 1;
                        s.mcd  = ($urandom_range(0, 3) == 0);
                        s.pc   = 1'($urandom_range(0, 1));
                        s.rsrc = 2'($urandom_range(0, 3));
                    end
                    default: begin
                        s.rsrc = 2'($urandom_range(0, 2));
                        if (s.rsrc == 2'b01) s.rsrc = 2'b11;
                    end
                endcase
            end
            step(s);
`ifdef HAZARD_PERF_CNT_EN
            if (i % 50 == 49) begin
                check("perf_stall_cycles_rand", stall_cycles_o, m_stalls_reg);
                check("perf_flush_events_rand", flush_events_o, m_flushes_reg);
            end
`endif
        end
        s = idle(); step(s);
        model(s, dummy);  // unused lookahead keeps nothing; just drain below
        @(negedge clk_i);
        #1;
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
